shift_add_mul: RTL and testbench
================================

Name: shift_add_mul

Overview:
- Sequential unsigned shift-and-add multiplier for the seq_mul datapath.
- Consumes operands from the upstream single-bit flip-flop register stage and produces a 2*WIDTH product, one partial-product step per clock.
- Start/busy/done handshake toward the surrounding control logic.
- Product is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits (unsigned); product width is 2*WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request a multiply; sampled on rising edge, honoured only in IDLE.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  single-cycle pulse; product valid from this cycle.
- product  output  2*WIDTH  result register; holds last result.

Behaviour:
- Reset (synchronous, any state): state=IDLE; busy=0, done=0, product=0, internal acc/count cleared. Reset overrides start in the same cycle.
- States: IDLE, RUN, DONE. 2-bit encoding: IDLE=0, RUN=1, DONE=2; code 3 is illegal and returns to IDLE.
- IDLE, on edge with start=1:
  - mcand<=a; acc<={WIDTH zeros, b}; count<=0; go to RUN.
  - product is unchanged until DONE.
- RUN, each edge:
  - If acc[0]=1: sum = acc[2W-1:W] + mcand, computed WIDTH+1 bits wide to keep the carry. Otherwise sum = {0, acc[2W-1:W]}.
  - acc <= {sum, acc[W-1:1]}, i.e. a logical right shift with the carry entering the MSB.
  - count<=count+1. When count==WIDTH-1, go to DONE.
- DONE, one cycle: product<=acc at the entry edge; done=1; busy=0; next edge goes to IDLE.
- Latency:
  - start sampled at edge 0; RUN occupies edges 1..WIDTH.
  - done=1 and product valid in the cycle after edge WIDTH+1; for WIDTH=8 that is the 9th clock after start.
  - Throughput is one result per WIDTH+2 cycles.
- start while RUN or DONE: ignored, no effect on acc, count or product. The next start is accepted the first cycle after DONE, in IDLE.
- a/b changes after the accepted start: no effect (operands already latched).
- Overflow: cannot occur. (2^W-1)^2 fits in 2W bits; the carry bit is consumed by the shift.
- Reset mid-RUN: computation is abandoned, no done pulse, product=0.
- Outputs are registered; there is no combinational path from start, a or b to any output.

Decomposition:
- Shared package (seq_mul_pkg):
  - state encoding constants ST_IDLE/ST_RUN/ST_DONE;
  - default WIDTH=8 and CNT_W=4.
- Sub-module shift_add_step: combinational one-iteration datapath. Inputs acc, mcand; output next acc. Instanced once, unit-testable alone.
- The FSM, counter and registers stay in shift_add_mul.

Test Plan:
- Reset release, idle 5 cycles, no start -> busy=0, done=0, product=0x0000 throughout.
- a=13, b=11, start for 1 cycle -> busy=1 for 8 cycles; done pulses exactly once, 9 cycles after start; product=0x008F (143), held until next start.
- a=255, b=255 -> product=0xFE01 (65025). a=0, b=200 -> 0x0000. a=1, b=255 -> 0x00FF. Each with done at start+9.
- start=1 held continuously with a=3, b=5, then a=7 changed mid-RUN -> one result 0x000F per 10-cycle period; mid-run operand changes ignored.
- Reset asserted during 4th RUN cycle of a=100, b=100 -> next edge: busy=0, done=0, product=0x0000; no done pulse follows.
- Back-to-back: 6x7, then start in the cycle after done with 12x12 -> product 0x002A, then 0x0090; start during DONE ignored.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the seq_mul datapath: FSM state codes and default sizing.
package seq_mul_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the upper
// half of the accumulator, then shift right one bit, keeping the carry in the MSB.
module shift_add_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0])
         sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      acc_next = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// One partial-product step per clock; product holds until the next result lands.
module shift_add_mul
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CNT_W-1:0]   count;

   shift_add_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         mcand   <= '0;
         acc     <= '0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mcand <= a;
                  acc   <= {{WIDTH{1'b0}}, b};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH-1)) begin
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // acc is final here; publishing it now gives done at start+WIDTH+1
               product <= acc;
               done    <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: the driver pushes expected products with
// their done cycle, a negedge monitor pops and compares on every done pulse.
module tb_shift_add_mul;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   typedef struct {
      logic [15:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   shift_add_mul #(.WIDTH(8), .CNT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done at cycle %0d: got done=1 product=0x%0h, expected no done", cyc, product);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_product", 32'(product), 32'(e.prod));
            check("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Single multiply with busy-window, single-pulse and hold checks.
   task automatic do_mul(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] expv);
      @(negedge clk);
      a = ai; b = bi; start = 1'b1;
      sb.push_back('{expv, cyc + 10});
      @(negedge clk);
      start = 1'b0;
      a = ~ai; b = ~bi;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         check("busy_window", 32'(busy), (i < 8) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
      check("product_after_done", 32'(product), 32'(expv));
      repeat (3) @(negedge clk);
      check("product_held", 32'(product), 32'(expv));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_product", 32'(product), 32'd0);
      end

      do_mul(8'd13,  8'd11,  16'h008F);
      do_mul(8'd255, 8'd255, 16'hFE01);
      do_mul(8'd0,   8'd200, 16'h0000);
      do_mul(8'd1,   8'd255, 16'h00FF);

      // start held high: accepted every 10 cycles, mid-run a changes ignored
      @(negedge clk);
      a = 8'd3; b = 8'd5; start = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back('{16'h000F, cyc + 10 + 10*k});
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k % 10 == 3) a = 8'd7;
         if (k % 10 == 8) a = 8'd3;
         if (k == 29) start = 1'b0;
      end
      @(negedge clk);
      check("held_start_drained", 32'(sb.size()), 32'd0);

      // reset during the 4th RUN cycle abandons the multiply
      @(negedge clk);
      a = 8'd100; b = 8'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      repeat (15) @(negedge clk);
      check("rst_no_done_product", 32'(product), 32'd0);

      // back-to-back: start in DONE ignored, start in the done cycle accepted
      @(negedge clk);
      a = 8'd6; b = 8'd7; start = 1'b1;
      sb.push_back('{16'h002A, cyc + 10});
      sb.push_back('{16'h0090, cyc + 20});
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 8) begin a = 8'd9;  b = 8'd9;  start = 1'b1; end
         if (k == 9) begin a = 8'd12; b = 8'd12; end
      end
      @(negedge clk);
      start = 1'b0;
      begin
         int budget = 50;
         while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
      end
      check("b2b_drained", 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clk);
      check("b2b_final_product", 32'(product), 32'h0090);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
